// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit and its ALU decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExecR, StExecI,
        StAluWb, StJal, StJalr, StJlink, StBranch, StLui, StAuipc, StTrap
    } state_e;

    typedef enum logic [1:0] {AluOpNone, AluOpAdd, AluOpSub, AluOpFunct} alu_op_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSll  = 4'b0001;
    localparam logic [3:0] AluSlt  = 4'b0111;
    localparam logic [3:0] AluSltu = 4'b1001;
    localparam logic [3:0] AluXor  = 4'b0000;
    localparam logic [3:0] AluSrl  = 4'b0101;
    localparam logic [3:0] AluSra  = 4'b0100;
    localparam logic [3:0] AluOr   = 4'b1000;
    localparam logic [3:0] AluAnd  = 4'b0011;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    function automatic logic [2:0] imm_sel(logic [6:0] op);
        case (op)
            OpStore:         return ImmS;
            OpBranch:        return ImmB;
            OpJal:           return ImmJ;
            OpLui, OpAuipc:  return ImmU;
            default:         return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_hs_if.sv
// Instruction/status inputs and datapath control outputs of the multicycle controller.
interface mc_control_hs_if #(
    parameter int unsigned ALU_CTRL_W = 4
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic                  zero;
    logic                  lt;
    logic                  ltu;
    logic                  mem_ready;
    logic                  trap_ack;
    logic                  pc_write;
    logic                  reg_write;
    logic                  ir_write;
    logic                  mem_req;
    logic                  mem_write;
    logic                  adr_src;
    logic [1:0]            result_src;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [2:0]            imm_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  trap;
    logic [1:0]            trap_cause;
    logic [3:0]            state_o;

    modport master (
        input  op, funct3, funct7_5, zero, lt, ltu, mem_ready, trap_ack,
        output pc_write, reg_write, ir_write, mem_req, mem_write, adr_src, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, trap, trap_cause, state_o
    );

    modport slave (
        output op, funct3, funct7_5, zero, lt, ltu, mem_ready, trap_ack,
        input  pc_write, reg_write, ir_write, mem_req, mem_write, adr_src, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, trap, trap_cause, state_o
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps the controller's ALU request plus funct fields to an ALU code.
module mc_alu_dec
    import mc_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [3:0] alu_control
);
    always_comb begin
        alu_control = 4'b0000;
        case (alu_op)
            AluOpAdd: alu_control = AluAdd;
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // addi has no subtract form, so funct7_5 only matters for R-type
                    3'b000: alu_control = (is_rtype && funct7_5) ? AluSub : AluAdd;
                    3'b001: alu_control = AluSll;
                    3'b010: alu_control = AluSlt;
                    3'b011: alu_control = AluSltu;
                    3'b100: alu_control = AluXor;
                    3'b101: alu_control = funct7_5 ? AluSra : AluSrl;
                    3'b110: alu_control = AluOr;
                    default: alu_control = AluAnd;
                endcase
            end
            default: alu_control = 4'b0000;
        endcase
    end
endmodule

// File: rtl/mc_control_hs.sv
// Multicycle RV32I main controller with memory handshake, wait timeout and trap state.
module mc_control_hs
    import mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    mc_control_hs_if.master bus
);
    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    alu_op_e         alu_op;
    logic            is_rtype, ready, mem_req, timeout_hit;
    logic [3:0]      alu_code;

    // Reset masks the handshake so outputs look like an idle FETCH while held in reset
    assign ready = bus.mem_ready & reset_n;

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        alu_op         = AluOpNone;
        is_rtype       = 1'b0;
        mem_req        = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = ResAluOut;
        bus.alu_src_a  = SrcAPc;
        bus.alu_src_b  = SrcBRs2;
        bus.trap       = 1'b0;
        bus.trap_cause = CauseNone;
        unique case (state_q)
            StFetch: begin
                mem_req        = reset_n;
                bus.alu_src_b  = SrcBFour;
                alu_op         = AluOpAdd;
                bus.result_src = ResAluResult;
                if (ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                bus.alu_src_a = SrcAOldPc;
                bus.alu_src_b = SrcBImm;
                alu_op        = AluOpAdd;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpImm:           state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpBranch:        state_d = StBranch;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMemAdr: begin
                bus.alu_src_a = SrcARs1;
                bus.alu_src_b = SrcBImm;
                alu_op        = AluOpAdd;
                state_d       = (bus.op == OpStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_req     = 1'b1;
                bus.adr_src = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.result_src = ResData;
                bus.reg_write  = 1'b1;
                state_d        = StFetch;
            end
            StMemWr: begin
                mem_req       = 1'b1;
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
                if (ready) state_d = StFetch;
            end
            StExecR: begin
                bus.alu_src_a = SrcARs1;
                alu_op        = AluOpFunct;
                is_rtype      = 1'b1;
                state_d       = StAluWb;
            end
            StExecI: begin
                bus.alu_src_a = SrcARs1;
                bus.alu_src_b = SrcBImm;
                alu_op        = AluOpFunct;
                state_d       = StAluWb;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
                state_d       = StFetch;
            end
            StJal: begin
                bus.pc_write  = 1'b1;
                bus.alu_src_a = SrcAOldPc;
                bus.alu_src_b = SrcBFour;
                alu_op        = AluOpAdd;
                state_d       = StAluWb;
            end
            StJalr: begin
                bus.alu_src_a  = SrcARs1;
                bus.alu_src_b  = SrcBImm;
                alu_op         = AluOpAdd;
                bus.result_src = ResAluResult;
                bus.pc_write   = 1'b1;
                state_d        = StJlink;
            end
            StJlink: begin
                bus.alu_src_a = SrcAOldPc;
                bus.alu_src_b = SrcBFour;
                alu_op        = AluOpAdd;
                state_d       = StAluWb;
            end
            StBranch: begin
                bus.alu_src_a = SrcARs1;
                alu_op        = AluOpSub;
                state_d       = StFetch;
                case (bus.funct3)
                    3'b000: bus.pc_write = bus.zero;
                    3'b001: bus.pc_write = ~bus.zero;
                    3'b100: bus.pc_write = bus.lt;
                    3'b101: bus.pc_write = ~bus.lt;
                    3'b110: bus.pc_write = bus.ltu;
                    3'b111: bus.pc_write = ~bus.ltu;
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StLui: begin
                bus.alu_src_a = SrcAZero;
                bus.alu_src_b = SrcBImm;
                alu_op        = AluOpAdd;
                state_d       = StAluWb;
            end
            StAuipc: begin
                bus.alu_src_a = SrcAOldPc;
                bus.alu_src_b = SrcBImm;
                alu_op        = AluOpAdd;
                state_d       = StAluWb;
            end
            StTrap: begin
                bus.trap       = 1'b1;
                bus.trap_cause = cause_q;
                if (bus.trap_ack) begin
                    state_d = StFetch;
                    cause_d = CauseNone;
                end
            end
        endcase
        // A ready in the final allowed cycle still completes normally
        timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !ready &&
                      (wait_cnt_q == CntW'(MEM_TIMEOUT - 1));
        if (timeout_hit) begin
            state_d = StTrap;
            cause_d = CauseTimeout;
        end
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_req && !ready) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFetch;
            cause_q    <= CauseNone;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    mc_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7_5),
        .is_rtype    (is_rtype),
        .alu_control (alu_code)
    );

    assign bus.mem_req     = mem_req;
    assign bus.alu_control = ALU_CTRL_W'(alu_code);
    assign bus.imm_src     = imm_sel(bus.op);
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_mc_control_hs.sv
// Randomized instruction-level bench: expected state walk and outputs come from a path model.
module tb_mc_control_hs;
    localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
    localparam int SExecR = 6, SExecI = 7, SAluWb = 8, SJal = 9, SJalr = 10, SJlink = 11;
    localparam int SBranch = 12, SLui = 13, SAuipc = 14, STrap = 15;
    localparam int Timeout = 4;

    typedef struct {
        int st;
        bit rdy;
        bit ack;
        bit take;
        int cause;
    } step_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    step_t path[$];
    int   exp_a[16], exp_b[16], exp_res[16];

    always #5 clk = ~clk;

    mc_control_hs_if #(.ALU_CTRL_W(4)) bus ();

    mc_control_hs #(.ALU_CTRL_W(4), .MEM_TIMEOUT(Timeout)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void push(int st, bit rdy, bit ack, bit take, int cause);
        step_t s;
        s.st = st; s.rdy = rdy; s.ack = ack; s.take = take; s.cause = cause;
        path.push_back(s);
    endfunction

    // Memory wait of d idle cycles; returns 1 if it exceeds the timeout limit
    function automatic bit wait_phase(int st, int d);
        for (int i = 0; i < d && i < Timeout; i++) push(st, 0, 0, 0, 0);
        if (d >= Timeout) return 1;
        push(st, 1, 0, 0, 0);
        return 0;
    endfunction

    function automatic void trap_phase(int cause, int k);
        for (int i = 0; i < k; i++) push(STrap, 0, 0, 0, cause);
        push(STrap, 0, 1, 0, cause);
    endfunction

    function automatic bit branch_take(logic [2:0] f3, logic z, logic lt, logic ltu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            default: return !ltu;
        endcase
    endfunction

    function automatic void build(logic [6:0] op, logic [2:0] f3, logic z, logic lt, logic ltu,
                                  int df, int dm, int k);
        path.delete();
        if (wait_phase(SFetch, df)) begin
            trap_phase(2, k);
            return;
        end
        push(SDecode, 0, 0, 0, 0);
        case (op)
            7'b0000011: begin
                push(SMemAdr, 0, 0, 0, 0);
                if (wait_phase(SMemRd, dm)) trap_phase(2, k);
                else push(SMemWb, 0, 0, 0, 0);
            end
            7'b0100011: begin
                push(SMemAdr, 0, 0, 0, 0);
                if (wait_phase(SMemWr, dm)) trap_phase(2, k);
            end
            7'b0110011: begin push(SExecR, 0, 0, 0, 0); push(SAluWb, 0, 0, 0, 0); end
            7'b0010011: begin push(SExecI, 0, 0, 0, 0); push(SAluWb, 0, 0, 0, 0); end
            7'b1101111: begin push(SJal, 0, 0, 0, 0); push(SAluWb, 0, 0, 0, 0); end
            7'b1100111: begin
                push(SJalr, 0, 0, 0, 0); push(SJlink, 0, 0, 0, 0); push(SAluWb, 0, 0, 0, 0);
            end
            7'b0110111: begin push(SLui, 0, 0, 0, 0); push(SAluWb, 0, 0, 0, 0); end
            7'b0010111: begin push(SAuipc, 0, 0, 0, 0); push(SAluWb, 0, 0, 0, 0); end
            7'b1100011: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    push(SBranch, 0, 0, 0, 0);
                    trap_phase(1, k);
                end else begin
                    push(SBranch, 0, 0, branch_take(f3, z, lt, ltu), 0);
                end
            end
            default: trap_phase(1, k);
        endcase
    endfunction

    function automatic logic [31:0] alu_exp(int st, logic [2:0] f3, logic f7);
        case (st)
            SExecR, SExecI: begin
                case (f3)
                    3'b000:  return (st == SExecR && f7) ? 32'h6 : 32'h2;
                    3'b001:  return 32'h1;
                    3'b010:  return 32'h7;
                    3'b011:  return 32'h9;
                    3'b100:  return 32'h0;
                    3'b101:  return f7 ? 32'h4 : 32'h5;
                    3'b110:  return 32'h8;
                    default: return 32'h3;
                endcase
            end
            SBranch: return 32'h6;
            SFetch, SDecode, SMemAdr, SJal, SJalr, SJlink, SLui, SAuipc: return 32'h2;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] imm_exp(logic [6:0] op);
        case (op)
            7'b0100011:             return 1;
            7'b1100011:             return 2;
            7'b1101111:             return 3;
            7'b0110111, 7'b0010111: return 4;
            default:                return 0;
        endcase
    endfunction

    // Called at posedge+1 while the DUT sits in FETCH; returns there at posedge+1
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic lt, input logic ltu,
                             input int df, input int dm, input int k);
        int irw;
        bus.op = op; bus.funct3 = f3; bus.funct7_5 = f7;
        bus.zero = z; bus.lt = lt; bus.ltu = ltu;
        build(op, f3, z, lt, ltu, df, dm, k);
        irw = 0;
        foreach (path[i]) begin
            step_t s;
            s = path[i];
            bus.mem_ready = s.rdy;
            bus.trap_ack  = s.ack;
            @(negedge clk);
            irw += int'(bus.ir_write);
            check("state", 32'(bus.state_o), s.st);
            check("ir_write", 32'(bus.ir_write), 32'(s.st == SFetch && s.rdy));
            check("pc_write", 32'(bus.pc_write), 32'((s.st == SFetch && s.rdy) || s.st == SJal ||
                  s.st == SJalr || (s.st == SBranch && s.take)));
            check("reg_write", 32'(bus.reg_write), 32'(s.st == SMemWb || s.st == SAluWb));
            check("mem_req", 32'(bus.mem_req),
                  32'(s.st == SFetch || s.st == SMemRd || s.st == SMemWr));
            check("adr_src", 32'(bus.adr_src), 32'(s.st == SMemRd || s.st == SMemWr));
            check("mem_write", 32'(bus.mem_write), 32'(s.st == SMemWr));
            check("trap", 32'(bus.trap), 32'(s.st == STrap));
            check("trap_cause", 32'(bus.trap_cause), (s.st == STrap) ? s.cause : 0);
            check("alu_src_a", 32'(bus.alu_src_a), exp_a[s.st]);
            check("alu_src_b", 32'(bus.alu_src_b), exp_b[s.st]);
            check("result_src", 32'(bus.result_src), exp_res[s.st]);
            check("alu_control", 32'(bus.alu_control), alu_exp(s.st, f3, f7));
            check("imm_src", 32'(bus.imm_src), imm_exp(op));
            @(posedge clk);
            #1;
        end
        check("ir_pulses", irw, (df >= Timeout) ? 0 : 1);
        check("back_to_fetch", 32'(bus.state_o), SFetch);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] legal [9];
        logic [6:0] op;
        bit         ok;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                  7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
        foreach (exp_a[i]) begin exp_a[i] = 0; exp_b[i] = 0; exp_res[i] = 0; end
        exp_a[SDecode] = 1; exp_a[SMemAdr] = 2; exp_a[SExecR] = 2; exp_a[SExecI] = 2;
        exp_a[SJal] = 1; exp_a[SJalr] = 2; exp_a[SJlink] = 1; exp_a[SBranch] = 2;
        exp_a[SLui] = 3; exp_a[SAuipc] = 1;
        exp_b[SFetch] = 2; exp_b[SDecode] = 1; exp_b[SMemAdr] = 1; exp_b[SExecI] = 1;
        exp_b[SJal] = 2; exp_b[SJalr] = 1; exp_b[SJlink] = 2; exp_b[SLui] = 1; exp_b[SAuipc] = 1;
        exp_res[SFetch] = 2; exp_res[SMemWb] = 1; exp_res[SJalr] = 2;

        reset_n = 1'b0;
        bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
        bus.mem_ready = 1'b1; bus.trap_ack = 1'b0;
        #13;
        check("rst_state", 32'(bus.state_o), SFetch);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_ir_write", 32'(bus.ir_write), 0);
        check("rst_pc_write", 32'(bus.pc_write), 0);
        check("rst_trap", 32'(bus.trap), 0);
        check("rst_alu_src_b", 32'(bus.alu_src_b), 2);
        check("rst_result_src", 32'(bus.result_src), 2);
        check("rst_alu_control", 32'(bus.alu_control), 2);
        bus.mem_ready = 1'b0;
        release_reset();

        // lw with ready on the third cycle of FETCH and MEMRD: 9 cycles total
        run_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 2, 2, 0);
        run_instr(7'b1100011, 3'b001, 0, 0, 0, 0, 0, 0, 0);   // bne, taken
        run_instr(7'b1100011, 3'b100, 0, 0, 0, 0, 0, 0, 0);   // blt, not taken
        run_instr(7'b1100011, 3'b010, 0, 0, 0, 0, 0, 0, 1);   // illegal branch
        run_instr(7'b1100111, 3'b000, 0, 0, 0, 0, 0, 0, 0);   // jalr
        run_instr(7'b0100011, 3'b010, 0, 0, 0, 0, 0, 9, 2);   // sw, memory never ready
        run_instr(7'b0100011, 3'b010, 0, 0, 0, 0, 1, 3, 0);   // sw, ready in the last cycle
        run_instr(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0, 1);   // illegal opcode
        run_instr(7'b0110011, 3'b000, 1, 0, 0, 0, 0, 0, 0);   // sub
        run_instr(7'b0010011, 3'b000, 1, 0, 0, 0, 0, 0, 0);   // addi with funct7_5 set
        run_instr(7'b0010011, 3'b101, 1, 0, 0, 0, 3, 0, 0);   // srai

        // Asynchronous reset in the middle of a MEMRD wait
        bus.op = 7'b0000011; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("memrd_entered", 32'(bus.state_o), SMemRd);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(bus.state_o), SFetch);
        check("rst_mid_mem_req", 32'(bus.mem_req), 0);
        check("rst_mid_adr_src", 32'(bus.adr_src), 0);
        release_reset();

        // Asynchronous reset while sitting in TRAP
        bus.op = 7'b1111111; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        check("trap_entered", 32'(bus.state_o), STrap);
        check("trap_cause_set", 32'(bus.trap_cause), 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_trap_state", 32'(bus.state_o), SFetch);
        check("rst_trap_flag", 32'(bus.trap), 0);
        check("rst_trap_cause", 32'(bus.trap_cause), 0);
        release_reset();

        for (int n = 0; n < 300; n++) begin
            int df, dm;
            if ($urandom_range(0, 9) == 0) begin
                op = 7'b1111111;
                for (int t = 0; t < 20; t++) begin
                    op = 7'($urandom);
                    ok = 1;
                    foreach (legal[j]) if (legal[j] == op) ok = 0;
                    if (ok) break;
                end
                if (!ok) op = 7'b1111111;
            end else begin
                op = legal[$urandom_range(0, 8)];
            end
            df = ($urandom_range(0, 11) == 0) ? 4 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(0, 3));
            dm = ($urandom_range(0, 5) == 0) ? 4 + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 3));
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), df, dm, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mc_control_hs.md
MC_CONTROL_HS -- requirements
Module: mc_control_hs

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 4, alu_control width (>=4; codes zero-extended).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 0, memory-wait limit in cycles (0 = no timeout).
REQ-003 Ports (name direction width meaning): clk in 1 clock; reset_n in 1 reset, asynchronous, active-low.
REQ-004 Inputs: op in 7 opcode; funct3 in 3; funct7_5 in 1 instr[30]; zero in 1 ALU result zero; lt in 1 signed less-than; ltu in 1 unsigned less-than; mem_ready in 1 memory done; trap_ack in 1 trap acknowledge.
REQ-005 Outputs: pc_write, reg_write, ir_write, mem_req, mem_write, adr_src out 1 each; result_src, alu_src_a, alu_src_b out 2 each; imm_src out 3; alu_control out ALU_CTRL_W; trap out 1; trap_cause out 2; state_o out 4 current state.

Function
REQ-006 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, JAL, JALR, JLINK, BRANCH, LUI, AUIPC, TRAP; encodings 0..15 in that order on state_o.
REQ-007 Encodings: alu_src_a 00 PC, 01 OldPC, 10 rs1, 11 zero; alu_src_b 00 rs2, 01 imm, 10 const 4; result_src 00 ALUOut, 01 Data, 10 ALUResult; imm_src 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-008 Every output not listed for a state SHALL be 0 (no X driven).
REQ-009 FETCH: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, then -> DECODE; else stay.
REQ-010 DECODE: a=01, b=01, add; op 0000011/0100011 -> MEMADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1101111 -> JAL, 1100111 -> JALR, 1100011 -> BRANCH, 0110111 -> LUI, 0010111 -> AUIPC, other -> TRAP cause 01.
REQ-011 MEMADR: a=10, b=01, add; lw -> MEMRD, sw -> MEMWR.
REQ-012 MEMRD: mem_req=1, adr_src=1; -> MEMWB on mem_ready. MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-013 MEMWR: mem_req=1, mem_write=1, adr_src=1; -> FETCH on mem_ready (mem_write held until then).
REQ-014 EXEC_R: a=10, b=00, R-decode; EXEC_I: a=10, b=01, I-decode (funct7_5 ignored for funct3 000); both -> ALUWB. ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-015 JAL: result_src=00, pc_write=1, a=01, b=10, add -> ALUWB. JALR: a=10, b=01, add, result_src=10, pc_write=1 -> JLINK. JLINK: a=01, b=10, add -> ALUWB.
REQ-016 BRANCH: a=10, b=00, SUB, result_src=00; pc_write = take per funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu -> FETCH; funct3 010/011 -> TRAP cause 01, no pc_write.
REQ-017 LUI: a=11, b=01, add -> ALUWB. AUIPC: a=01, b=01, add -> ALUWB.
REQ-018 alu_control: ADD 0010, SUB 0110, SLL 0001, SLT 0111, SLTU 1001, XOR 0000, SRL 0101, SRA 0100, OR 1000, AND 0011; funct3 000 SUB only for R with funct7_5=1; 101 SRA when funct7_5=1.
REQ-019 imm_src decoded combinationally from op in all states; unlisted op -> 000.
REQ-020 Wait counter SHALL count cycles with mem_req=1 and mem_ready=0, clear on state change; if MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT -> TRAP cause 10, no ir_write/reg write.
REQ-021 mem_ready in the timeout cycle SHALL win (normal completion).
REQ-022 TRAP: trap=1, trap_cause held; -> FETCH on trap_ack, cause cleared to 00.

Reset
REQ-023 reset_n low SHALL force FETCH, counter 0, trap_cause 00 immediately, including mid-wait or in TRAP.
REQ-024 During reset outputs SHALL equal FETCH values with mem_ready=0 (mem_req=1 only after deassertion edge).

Structure
REQ-025 State enum, ALU codes, mux encodings and opcodes SHALL live in shared package mc_pkg.
REQ-026 ALU decode SHALL be sub-module mc_alu_dec (alu_op, funct3, funct7_5, is_rtype -> alu_control).

Verification
REQ-027 lw, mem_ready delayed 3 cycles in FETCH and MEMRD -> 9 cycles total, ir_write single pulse, reg_write in MEMWB.
REQ-028 bne zero=0, blt lt=0 -> pc_write 1 then 0 in BRANCH; funct3 010 -> TRAP cause 01.
REQ-029 jalr -> states DECODE,JALR,JLINK,ALUWB; pc_write in JALR with result_src=10.
REQ-030 MEM_TIMEOUT=4, mem_ready stuck 0 in MEMWR -> TRAP cause 10 after 4 cycles; trap_ack -> FETCH.
REQ-031 op 1111111 -> TRAP cause 01; reset_n low mid-MEMRD -> state_o 0 immediately.
REQ-032 R-type sub (funct7_5=1, funct3 000) -> 0110; addi with funct7_5=1 -> 0010.
